// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, mul/div FSM states.
package ex_pkg;

  typedef enum logic [4:0] {
    OP_NOP   = 5'h00,
    OP_AND   = 5'h01,
    OP_OR    = 5'h02,
    OP_XOR   = 5'h03,
    OP_NOR   = 5'h04,
    OP_SLL   = 5'h05,
    OP_SRL   = 5'h06,
    OP_SRA   = 5'h07,
    OP_MFHI  = 5'h08,
    OP_MFLO  = 5'h09,
    OP_MTHI  = 5'h0A,
    OP_MTLO  = 5'h0B,
    OP_MULT  = 5'h0C,
    OP_MULTU = 5'h0D,
    OP_DIV   = 5'h0E,
    OP_DIVU  = 5'h0F
  } aluop_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  localparam logic [31:0] ZeroWord = 32'h0;

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) with sign fix-up.
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               div_q, div_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod;

  assign busy_o = (state_q == MD_BUSY);
  assign done_o = (state_q == MD_DONE);

  // Operand magnitudes for signed ops, raw values for unsigned ops
  always_comb begin
    a_mag = (is_signed_i && a_i[WIDTH-1]) ? ('0 - a_i) : a_i;
    b_mag = (is_signed_i && b_i[WIDTH-1]) ? ('0 - b_i) : b_i;
  end

  // One radix-2 step: accumulator holds {partial, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    rem_sub = rem_sh[WIDTH-1:0] - opb_q;
    if (div_q) begin
      if (rem_sh >= {1'b0, opb_q}) step_acc = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
      else                         step_acc = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      if (acc_q[0]) step_acc = {sum, acc_q[WIDTH-1:1]};
      else          step_acc = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  // FSM next state and datapath load/step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i && !flush_i) begin
          div_d = is_div_i;
          cnt_d = '0;
          if (is_div_i && (b_i == '0)) begin
            // divide by zero: result is preloaded so DONE passes it through untouched
            acc_d   = {a_i, {WIDTH{1'b1}}};
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = MD_DONE;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            opb_d   = b_mag;
            negq_d  = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            negr_d  = is_signed_i & a_i[WIDTH-1];
            state_d = MD_BUSY;
          end
        end
      end
      MD_BUSY: begin
        if (flush_i) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = MD_DONE;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Sign correction of the unsigned result, valid while in DONE
  always_comb begin
    prod = negq_q ? ('0 - acc_q) : acc_q;
    if (div_q) begin
      hi_o = negr_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
      lo_o = negq_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    end else begin
      hi_o = prod[2*WIDTH-1:WIDTH];
      lo_o = prod[WIDTH-1:0];
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Execute stage: combinational ALU/shifter, HI/LO registers, iterative mul/div, stall request.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       aluop_i,
  input  logic [WIDTH-1:0] reg1_data_i,
  input  logic [WIDTH-1:0] reg2_data_i,
  input  logic [4:0]       waddr_i,
  input  logic             reg_we_i,
  input  logic             flush_i,
  output logic [4:0]       waddr_o,
  output logic             reg_we_o,
  output logic [WIDTH-1:0] alu_res_o,
  output logic             stall_req_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic             gpr_we, md_op, md_signed, md_div;
  logic             md_busy, md_done, md_start;
  logic [SHW-1:0]   shamt;

  assign shamt = reg2_data_i[SHW-1:0];

  // Opcode decode and zero-latency result
  always_comb begin
    alu_res   = '0;
    gpr_we    = 1'b1;
    md_op     = 1'b0;
    md_signed = 1'b0;
    md_div    = 1'b0;
    case (aluop_i)
      OP_NOP:  alu_res = '0;
      OP_AND:  alu_res = reg1_data_i & reg2_data_i;
      OP_OR:   alu_res = reg1_data_i | reg2_data_i;
      OP_XOR:  alu_res = reg1_data_i ^ reg2_data_i;
      OP_NOR:  alu_res = ~(reg1_data_i | reg2_data_i);
      OP_SLL:  alu_res = reg1_data_i << shamt;
      OP_SRL:  alu_res = reg1_data_i >> shamt;
      OP_SRA:  alu_res = $signed(reg1_data_i) >>> shamt;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_MTHI, OP_MTLO: gpr_we = 1'b0;
      OP_MULT:  begin md_op = 1'b1; md_signed = 1'b1; gpr_we = 1'b0; end
      OP_MULTU: begin md_op = 1'b1; gpr_we = 1'b0; end
      OP_DIV:   begin md_op = 1'b1; md_signed = 1'b1; md_div = 1'b1; gpr_we = 1'b0; end
      OP_DIVU:  begin md_op = 1'b1; md_div = 1'b1; gpr_we = 1'b0; end
      default:  gpr_we = 1'b0;
    endcase
  end

  assign md_start    = md_op & ~flush_i;
  // stall from the accepting IDLE cycle through BUSY; DONE lets the pipeline advance
  assign stall_req_o = ~rst & ~flush_i & (md_busy | (md_op & ~md_done));
  assign alu_res_o   = rst ? '0 : alu_res;
  assign waddr_o     = rst ? '0 : waddr_i;
  assign reg_we_o    = ~rst & reg_we_i & gpr_we;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk         (clk),
    .rst         (rst),
    .start_i     (md_start),
    .flush_i     (flush_i),
    .is_div_i    (md_div),
    .is_signed_i (md_signed),
    .a_i         (reg1_data_i),
    .b_i         (reg2_data_i),
    .busy_o      (md_busy),
    .done_o      (md_done),
    .hi_o        (md_hi),
    .lo_o        (md_lo)
  );

  // HI/LO update: mul/div completion or MTHI/MTLO when not stalled or flushed
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (md_done && !flush_i) begin
      hi_d = md_hi;
      lo_d = md_lo;
    end else if (!stall_req_o && !flush_i) begin
      if (aluop_i == OP_MTHI) hi_d = reg1_data_i;
      if (aluop_i == OP_MTLO) lo_d = reg1_data_i;
    end
  end

  // HI/LO architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule
